// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and lane-offset helper for the 1-to-8 demux bank.
package demux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, BCAST} state_e;

  function automatic int lane_slice(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: holds a word until acked; a load in the same cycle as an ack wins.
module demux_lane_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              ack,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q
);
  logic [DATA_W-1:0] data_d;
  logic              valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/demux8_bank.sv
// Registered 1-to-8 demux with per-lane hold-until-ack and a sequential in-order broadcast.
module demux8_bank
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  input  logic [DATA_W-1:0]       in_data,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_valid,
  input  logic [LANES-1:0]        out_ack
);
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  bcast_idx_q, bcast_idx_d;
  logic [DATA_W-1:0] bcast_hold_q, bcast_hold_d;
  logic [LANES-1:0]  free, load;
  logic [DATA_W-1:0] lane_din;

  assign free = ~out_valid | out_ack;

  always_comb begin
    state_d      = state_q;
    bcast_idx_d  = bcast_idx_q;
    bcast_hold_d = bcast_hold_q;
    load         = '0;
    lane_din     = in_data;
    in_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_bcast) begin
          in_ready = 1'b1;
          if (in_valid) begin
            bcast_hold_d = in_data;
            bcast_idx_d  = '0;
            state_d      = BCAST;
          end
        end else begin
          in_ready = free[in_sel];
          if (in_valid && free[in_sel]) load[in_sel] = 1'b1;
        end
      end
      BCAST: begin
        // Strictly in-order fill; stall on the current lane until it frees up.
        lane_din = bcast_hold_q;
        if (free[bcast_idx_q]) begin
          load[bcast_idx_q] = 1'b1;
          bcast_idx_d       = bcast_idx_q + SEL_W'(1);
          if (bcast_idx_q == SEL_W'(LANES - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bcast_idx_q  <= '0;
      bcast_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      bcast_idx_q  <= bcast_idx_d;
      bcast_hold_q <= bcast_hold_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_reg #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load[g]),
      .ack     (out_ack[g]),
      .din     (lane_din),
      .data_q  (out_data[lane_slice(g, DATA_W) +: DATA_W]),
      .valid_q (out_valid[g])
    );
  end
endmodule

// File: tb/tb_demux8_bank.sv
// Directed self-checking bench for demux8_bank: reset, unicast, ack/write overlap, broadcast, stall.
module tb_demux8_bank;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_sel = '0;
  logic          in_bcast = 1'b0;
  logic [31:0]   in_data = '0;
  logic [255:0]  out_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ack = '0;

  int checks = 0;
  int errors = 0;

  demux8_bank #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane(input int k);
    return out_data[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Out of reset, park lane 3 with a word, then reset asynchronously mid-stream
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    tick;
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h33;
    tick;
    in_valid = 1'b0;
    chk("lane3_loaded", 256'(out_valid), 256'(8'h08));
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 256'(out_valid), 256'(8'h00));
    chk("rst_data", out_data, 256'h0);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1 chk("rst_ready", 256'(in_ready), 256'(1'b1));
    end
    @(negedge clk); reset = 1'b0;
    tick;

    // Unicast to lane 5, then a blocked second send until ack
    in_valid = 1'b1; in_sel = 3'd5; in_data = 32'hDEADBEEF;
    #1 chk("uc_ready", 256'(in_ready), 256'(1'b1));
    tick;
    chk("uc_valid", 256'(out_valid), 256'(8'h20));
    chk("uc_data", 256'(lane(5)), 256'(32'hDEADBEEF));
    in_data = 32'h12345678;
    #1 chk("uc_blocked", 256'(in_ready), 256'(1'b0));
    tick;
    chk("uc_hold_data", 256'(lane(5)), 256'(32'hDEADBEEF));
    chk("uc_hold_ready", 256'(in_ready), 256'(1'b0));
    out_ack = 8'h20;
    #1 chk("uc_ack_ready", 256'(in_ready), 256'(1'b1));
    tick;
    in_valid = 1'b0; out_ack = '0;
    chk("uc2_valid", 256'(out_valid), 256'(8'h20));
    chk("uc2_data", 256'(lane(5)), 256'(32'h12345678));
    out_ack = 8'h20;
    tick;
    out_ack = '0;
    chk("ack_clear", 256'(out_valid), 256'(8'h00));
    chk("ack_retain", 256'(lane(5)), 256'(32'h12345678));

    // Same-cycle ack and write on lane 2
    in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h11;
    tick;
    chk("l2_first", 256'(lane(2)), 256'(32'h11));
    in_data = 32'h22; out_ack = 8'h04;
    #1 chk("l2_ready", 256'(in_ready), 256'(1'b1));
    tick;
    in_valid = 1'b0; out_ack = '0;
    chk("l2_valid", 256'(out_valid), 256'(8'h04));
    chk("l2_data", 256'(lane(2)), 256'(32'h22));
    out_ack = 8'h04;
    tick;
    out_ack = 8'hFF;
    tick;
    out_ack = '0;
    chk("ack_idle_ignored", 256'(out_valid), 256'(8'h00));

    // Stall-free broadcast
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 32'hA5A5A5A5;
    #1 chk("bc_ready", 256'(in_ready), 256'(1'b1));
    tick;
    in_valid = 1'b0;
    chk("bc_capture_valid", 256'(out_valid), 256'(8'h00));
    chk("bc_capture_ready", 256'(in_ready), 256'(1'b0));
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk("bc_fill", 256'(out_valid), 256'((9'h1 << i) - 9'h1));
      chk("bc_ready_seq", 256'(in_ready), 256'(i == 8));
    end
    for (int k = 0; k < 8; k++) chk("bc_data", 256'(lane(k)), 256'(32'hA5A5A5A5));
    out_ack = 8'hFF;
    tick;
    out_ack = '0;

    // Broadcast stalls on lane 4 until it is acked
    in_bcast = 1'b0; in_valid = 1'b1; in_sel = 3'd4; in_data = 32'h44;
    tick;
    in_bcast = 1'b1; in_data = 32'h7;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    chk("st_reach", 256'(out_valid), 256'(8'h1F));
    repeat (3) tick;
    chk("st_hold_valid", 256'(out_valid), 256'(8'h1F));
    chk("st_hold_data", 256'(lane(4)), 256'(32'h44));
    chk("st_hold_ready", 256'(in_ready), 256'(1'b0));
    out_ack = 8'h10;
    #1 chk("st_ack_ready", 256'(in_ready), 256'(1'b0));
    tick;
    out_ack = '0;
    chk("st_l4", 256'(lane(4)), 256'(32'h7));
    chk("st_l4_valid", 256'(out_valid), 256'(8'h1F));
    tick; chk("st_5", 256'(out_valid), 256'(8'h3F));
    tick; chk("st_6", 256'(out_valid), 256'(8'h7F));
    chk("st_busy", 256'(in_ready), 256'(1'b0));
    tick; chk("st_7", 256'(out_valid), 256'(8'hFF));
    chk("st_done_ready", 256'(in_ready), 256'(1'b1));
    for (int k = 4; k < 8; k++) chk("st_data", 256'(lane(k)), 256'(32'h7));
    out_ack = 8'hFF;
    tick;
    out_ack = '0;

    // Reset while bcast_idx == 3
    in_valid = 1'b1; in_data = 32'h9;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    chk("rb_partial", 256'(out_valid), 256'(8'h07));
    #2 reset = 1'b1;
    #1;
    chk("rb_valid", 256'(out_valid), 256'(8'h00));
    chk("rb_data", out_data, 256'h0);
    chk("rb_ready", 256'(in_ready), 256'(1'b1));
    @(negedge clk); reset = 1'b0;
    tick;
    in_bcast = 1'b0; in_valid = 1'b1; in_sel = 3'd6; in_data = 32'h66;
    tick;
    in_valid = 1'b0;
    chk("rb_uc_valid", 256'(out_valid), 256'(8'h40));
    chk("rb_uc_data", 256'(lane(6)), 256'(32'h66));
    tick;
    chk("rb_no_bcast", 256'(out_valid), 256'(8'h40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux8_bank.md
Name: demux8_bank

Overview:
- Registered 1-to-8 demultiplexer: the distribution counterpart of the 8-input word selector used on datapath read paths.
- Routes one incoming 32-bit word to one of eight output lanes, or broadcasts it to all eight.
- Holds each delivered word in a per-lane register until the consumer on that lane acknowledges it.
- Sits between a single producer (ALU/memory-data path) and up to eight consumers in the multicycle datapath.

Parameters:
- DATA_W, 32, width of in_data and of each output lane.
- Lane count is fixed at 8. Selector width is fixed at 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a word this cycle.
- in_ready  output  1  block accepts the offered word this cycle. Combinational.
- in_sel  input  3  target lane for a unicast word. Ignored when in_bcast=1.
- in_bcast  input  1  offered word goes to all 8 lanes.
- in_data  input  DATA_W  offered word.
- out_data  output  8*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]. Registered.
- out_valid  output  8  lane k holds an unconsumed word. Registered.
- out_ack  input  8  consumer k takes lane k's word this cycle.

Behaviour:
- Reset (asynchronous, any time including mid-broadcast):
  - out_data = 0, out_valid = 0, state = IDLE, bcast_idx = 0, bcast_hold = 0.
  - Any pending or partial broadcast is discarded.
- Transfer rule: the input handshake occurs when in_valid & in_ready are both 1 at a rising edge.
- Lane free condition: free[k] = ~out_valid[k] | out_ack[k] (same cycle).
- State IDLE, unicast (in_bcast=0):
  - in_ready = free[in_sel].
  - On handshake: out_data[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency is 1 cycle; the word is visible the cycle after the handshake.
- State IDLE, broadcast (in_bcast=1):
  - in_ready = 1.
  - On handshake: bcast_hold <= in_data, bcast_idx <= 0, state <= BCAST. No lane is written in that cycle.
- State BCAST:
  - in_ready = 0.
  - Each cycle, if free[bcast_idx]: out_data[bcast_idx] <= bcast_hold, out_valid[bcast_idx] <= 1, bcast_idx <= bcast_idx + 1.
  - Otherwise the block stalls on that lane (bcast_idx holds).
  - Lanes are written strictly in order 0..7.
  - After lane 7 is written: state <= IDLE, bcast_idx wraps to 0.
  - A stall-free broadcast takes 9 cycles from handshake to in_ready high again: 1 cycle to capture, 8 cycles to write.
- Acknowledge, on any lane k with no write to k this cycle:
  - out_ack[k] & out_valid[k] clears out_valid[k].
  - out_data[k] retains its last value; it is not zeroed.
  - out_ack[k] while out_valid[k]=0 is ignored.
- Simultaneous ack and write on the same lane: the new word is loaded and out_valid stays 1. There is no bubble.
- Lanes not targeted are unaffected, apart from their own acks.
- in_sel and in_data may change freely while in_ready=0. They are sampled only on a handshake.
- Outputs never change except on a clk edge or on reset.

Decomposition:
- Shared package demux_pkg:
  - LANES = 8 and SEL_W = 3.
  - State enum {IDLE, BCAST}.
  - Function lane_slice(k) returning the out_data bit offset.
- One natural sub-module, demux_lane_reg: a single lane register (data plus valid) with load, ack and the load-over-ack priority. It is instantiated 8 times.
- The top level holds the FSM, bcast_idx, bcast_hold and the in_ready decode.

Test Plan:
- Reset check: assert reset mid-stream with lane 3 valid -> out_valid=8'h00, out_data all zeros, and in_ready=1 for any in_sel with in_bcast=0.
- Unicast: send in_sel=5, data 32'hDEADBEEF with in_valid=1 -> next cycle out_valid=8'h20, lane 5 = DEADBEEF. A second send to lane 5 with no ack -> in_ready=0 until out_ack[5] is pulsed.
- Same-cycle ack and write: lane 2 is valid with 32'h11. Pulse out_ack[2] while sending 32'h22 to lane 2 -> handshake occurs, next cycle lane 2 = 32'h22 and out_valid[2]=1.
- Broadcast: all lanes empty, send in_bcast=1 with data 32'hA5A5A5A5 -> out_valid fills 01, 03, 07 ... FF on successive cycles. in_ready is 0 for 8 cycles after the handshake cycle and returns to 1 on the 9th.
- Broadcast stall: lane 4 is valid and unacked, then broadcast 32'h7 -> out_valid reaches 8'h1F and bcast_idx holds at 4. Ack lane 4 -> writes resume and lanes 4..7 receive 32'h7. in_ready stays 0 throughout the stall.
- Reset mid-broadcast: assert reset when bcast_idx=3 -> all outputs clear immediately. After reset is released, a unicast to lane 6 completes with 1-cycle latency.
